// File: rtl/multdiv_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_issue_ctrl_pkg
// Description : Shared FSM encoding and constants for the multdiv issue control.
// Revision    : 1.0 - initial release
// ============================================================================
package multdiv_issue_ctrl_pkg;

   localparam int c_TIMEOUT_DEFAULT = 40;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } md_state_e;

   // The extra bit lets the saturating counter hold TIMEOUT itself.
   function automatic int md_cnt_width(input int timeout);
      return $clog2(timeout) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/multdiv_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_issue_ctrl_if
// Description : Decode, multdiv-unit and writeback signals of the issue control.
// Revision    : 1.0 - initial release
// ============================================================================
interface multdiv_issue_ctrl_if;

   logic        op_valid;
   logic        is_mult;
   logic        is_div;
   logic [31:0] op_A;
   logic [31:0] op_B;
   logic [4:0]  op_dest;

   logic [31:0] md_operandA;
   logic [31:0] md_operandB;
   logic        md_ctrl_MULT;
   logic        md_ctrl_DIV;
   logic [31:0] md_result;
   logic        md_exception;
   logic        md_resultRDY;

   logic        stall;
   logic        wb_valid;
   logic [31:0] wb_result;
   logic [4:0]  wb_dest;
   logic        wb_exception;
   logic        wb_timeout;

   modport master (
      output op_valid, is_mult, is_div, op_A, op_B, op_dest,
      output md_result, md_exception, md_resultRDY,
      input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
      input  stall, wb_valid, wb_result, wb_dest, wb_exception, wb_timeout
   );

   modport slave (
      input  op_valid, is_mult, is_div, op_A, op_B, op_dest,
      input  md_result, md_exception, md_resultRDY,
      output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
      output stall, wb_valid, wb_result, wb_dest, wb_exception, wb_timeout
   );

endinterface
`default_nettype wire

// File: rtl/multdiv_issue_ctrl_md_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : dffe_ref / md_wait_counter
// Description : Enable flop and the saturating WAIT-cycle counter built on it.
// Revision    : 1.0 - initial release
// ============================================================================
module dffe_ref (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_d,
   output logic o_q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_q <= 1'b0;
      end else if (i_en) begin
         o_q <= i_d;
      end
   end

endmodule

module md_wait_counter #(
   parameter int WIDTH    = 7,
   parameter int TERMINAL = 39
)(
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tc
);

   localparam logic [WIDTH-1:0] c_TC = WIDTH'(TERMINAL);

   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_sat;
   logic             w_en;

   assign w_sat     = &r_count;
   assign w_en      = i_clear | (i_enable & ~w_sat);
   assign w_cnt_nxt = i_clear ? '0 : (r_count + WIDTH'(1));
   assign o_tc      = (r_count == c_TC);

   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      dffe_ref u_ff (
         .clk  (clk),
         .rst  (rst),
         .i_en (w_en),
         .i_d  (w_cnt_nxt[gi]),
         .o_q  (r_count[gi])
      );
   end

endmodule
`default_nettype wire

// File: rtl/multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_issue_ctrl
// Description : Issues one multiply/divide to the multdiv unit and returns its
//               result (or a timeout) on the writeback port.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_issue_ctrl
   import multdiv_issue_ctrl_pkg::*;
#(
   parameter int TIMEOUT = c_TIMEOUT_DEFAULT
)(
   input  logic                 clk,
   input  logic                 rst,
   multdiv_issue_ctrl_if.slave  bus
);

   localparam int c_CNT_W = md_cnt_width(TIMEOUT);

   md_state_e   r_state;
   md_state_e   w_state_nxt;
   logic [31:0] r_op_a;
   logic [31:0] r_op_b;
   logic [4:0]  r_dest;
   logic        r_is_div;
   logic [31:0] r_wb_result;
   logic        r_wb_exc;
   logic        r_wb_to;

   logic        w_legal_op;
   logic        w_accept;
   logic        w_cnt_clear;
   logic        w_cnt_en;
   logic        w_cnt_tc;

   assign w_legal_op  = bus.op_valid & (bus.is_mult | bus.is_div);
   assign w_accept    = ((r_state == ST_IDLE) | (r_state == ST_DONE)) & w_legal_op;
   assign w_cnt_clear = (r_state == ST_START);
   assign w_cnt_en    = (r_state == ST_WAIT) & ~bus.md_resultRDY;

   md_wait_counter #(
      .WIDTH    (c_CNT_W),
      .TERMINAL (TIMEOUT - 1)
   ) u_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_cnt_clear),
      .i_enable (w_cnt_en),
      .o_tc     (w_cnt_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // START never looks at md_resultRDY: it may still be the previous op's ready.
   always_comb begin
      w_state_nxt      = r_state;
      bus.md_ctrl_MULT = 1'b0;
      bus.md_ctrl_DIV  = 1'b0;
      bus.wb_valid     = 1'b0;
      bus.wb_result    = 32'd0;
      bus.wb_dest      = 5'd0;
      bus.wb_exception = 1'b0;
      bus.wb_timeout   = 1'b0;
      bus.stall        = w_accept;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_START;
            end
         end
         ST_START: begin
            bus.md_ctrl_MULT = ~r_is_div;
            bus.md_ctrl_DIV  = r_is_div;
            bus.stall        = 1'b1;
            w_state_nxt      = ST_WAIT;
         end
         ST_WAIT: begin
            bus.stall = 1'b1;
            if (bus.md_resultRDY || w_cnt_tc) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.wb_valid     = 1'b1;
            bus.wb_result    = r_wb_result;
            bus.wb_dest      = r_dest;
            bus.wb_exception = r_wb_exc;
            bus.wb_timeout   = r_wb_to;
            w_state_nxt      = w_accept ? ST_START : ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op_a      <= 32'd0;
         r_op_b      <= 32'd0;
         r_dest      <= 5'd0;
         r_is_div    <= 1'b0;
         r_wb_result <= 32'd0;
         r_wb_exc    <= 1'b0;
         r_wb_to     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op_a   <= bus.op_A;
            r_op_b   <= bus.op_B;
            r_dest   <= bus.op_dest;
            r_is_div <= bus.is_div;
         end
         if (r_state == ST_WAIT) begin
            if (bus.md_resultRDY) begin
               r_wb_result <= bus.md_result;
               r_wb_exc    <= bus.md_exception;
               r_wb_to     <= 1'b0;
            end else if (w_cnt_tc) begin
               r_wb_result <= 32'd0;
               r_wb_exc    <= 1'b1;
               r_wb_to     <= 1'b1;
            end
         end
      end
   end

   assign bus.md_operandA = r_op_a;
   assign bus.md_operandB = r_op_b;

endmodule
`default_nettype wire

// File: tb/tb_multdiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multdiv_issue_ctrl
// Description : Self-checking bench with a latency-programmable multdiv model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_issue_ctrl;

   localparam int TO = 40;

   typedef struct {
      string       nm;
      bit          m;
      bit          d;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dst;
      int          lat;
      logic [31:0] er;
      bit          ee;
      bit          et;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   multdiv_issue_ctrl_if bus();

   multdiv_issue_ctrl #(.TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural multdiv unit: result is returned lat WAIT cycles after the
   // start pulse; ready and result stay up until the next pulse is seen.
   int          md_lat = 0;
   int          md_lat_cur;
   int          md_k;
   bit          md_pend = 0;
   bit          md_div;
   logic [31:0] md_a, md_b;

   function automatic logic [32:0] md_calc(input bit div, input logic [31:0] a, input logic [31:0] b);
      if (!div)       return {1'b0, a * b};
      else if (b == 0) return {1'b1, 32'd0};
      else            return {1'b0, 32'($signed(a) / $signed(b))};
   endfunction

   initial begin
      logic [32:0] res;
      bus.md_resultRDY = 1'b0;
      bus.md_result    = 32'd0;
      bus.md_exception = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.md_ctrl_MULT || bus.md_ctrl_DIV) begin
            md_pend    = 1;
            md_k       = 0;
            md_lat_cur = md_lat;
            md_div     = bus.md_ctrl_DIV;
            md_a       = bus.md_operandA;
            md_b       = bus.md_operandB;
         end else if (md_pend) begin
            md_k++;
            if (md_k == md_lat_cur + 1) begin
               res              = md_calc(md_div, md_a, md_b);
               bus.md_result    = res[31:0];
               bus.md_exception = res[32];
               bus.md_resultRDY = 1'b1;
               md_pend          = 0;
            end else begin
               bus.md_resultRDY = 1'b0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_op(input bit v, input bit m, input bit d,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] dst);
      bus.op_valid = v;
      bus.is_mult  = m;
      bus.is_div   = d;
      bus.op_A     = a;
      bus.op_B     = b;
      bus.op_dest  = dst;
   endtask

   task automatic run_op(input vec_t v);
      int exp_lat, c, stall_cnt, mp, dp, pulse_cyc, opnd_bad, quiet_bad;
      bit got;
      exp_lat   = 3 + ((v.lat >= TO) ? TO - 1 : v.lat);
      stall_cnt = 0; mp = 0; dp = 0; pulse_cyc = -1; opnd_bad = 0; quiet_bad = 0; got = 0;
      md_lat    = v.lat;
      @(posedge clk); #1;
      drive_op(1, v.m, v.d, v.a, v.b, v.dst);
      @(negedge clk);
      chk({v.nm, " stall_accept"}, bus.stall, 1);
      @(posedge clk); #1;
      drive_op(0, 0, 0, $urandom, $urandom, 5'($urandom));
      for (c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (bus.stall) stall_cnt++;
         if (bus.md_ctrl_MULT) begin mp++; pulse_cyc = c; end
         if (bus.md_ctrl_DIV)  begin dp++; pulse_cyc = c; end
         if (bus.md_operandA !== v.a || bus.md_operandB !== v.b) opnd_bad++;
         if (bus.wb_valid) begin got = 1; break; end
         if (bus.wb_result != 0 || bus.wb_dest != 0 || bus.wb_exception || bus.wb_timeout) quiet_bad++;
      end
      chk({v.nm, " wb_seen"},    32'(got), 1);
      chk({v.nm, " latency"},    c, exp_lat);
      chk({v.nm, " stall_cyc"},  stall_cnt, exp_lat - 1);
      chk({v.nm, " mult_pulse"}, mp, (v.m && !v.d) ? 1 : 0);
      chk({v.nm, " div_pulse"},  dp, v.d ? 1 : 0);
      chk({v.nm, " pulse_cyc"},  pulse_cyc, 1);
      chk({v.nm, " opnd_hold"},  opnd_bad, 0);
      chk({v.nm, " wb_quiet"},   quiet_bad, 0);
      chk({v.nm, " wb_result"},  bus.wb_result, v.er);
      chk({v.nm, " wb_dest"},    bus.wb_dest, v.dst);
      chk({v.nm, " wb_exc"},     bus.wb_exception, v.ee);
      chk({v.nm, " wb_timeout"}, bus.wb_timeout, v.et);
      @(negedge clk);
      chk({v.nm, " wb_one_cyc"}, bus.wb_valid, 0);
   endtask

   task automatic run_illegal(input string nm);
      int bad = 0;
      @(posedge clk); #1;
      drive_op(1, 0, 0, $urandom, $urandom, 5'($urandom));
      @(negedge clk);
      chk({nm, " stall"}, bus.stall, 0);
      @(posedge clk); #1;
      drive_op(0, 0, 0, 0, 0, 0);
      repeat (4) begin
         @(negedge clk);
         if (bus.stall || bus.md_ctrl_MULT || bus.md_ctrl_DIV || bus.wb_valid) bad++;
      end
      chk({nm, " no_activity"}, bad, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got hang expected finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[8];
      vec_t rv;
      logic [32:0] r;
      int   wb_cyc[$];
      logic [31:0] wb_res[$];
      logic [4:0]  wb_dst[$];
      int   mul_cyc, bad;

      tbl[0] = '{"mul6x7",    1, 0, 32'd6,          32'd7,  5'd4,  17,   32'd42,         0, 0};
      tbl[1] = '{"div100by0", 0, 1, 32'd100,        32'd0,  5'd17, 5,    32'd0,          1, 0};
      tbl[2] = '{"mul_never", 1, 0, 32'd3,          32'd4,  5'd1,  1000, 32'd0,          1, 1};
      tbl[3] = '{"both_div",  1, 1, 32'd50,         32'd5,  5'd30, 3,    32'd10,         0, 0};
      tbl[4] = '{"div_lat39", 0, 1, 32'd1000,       32'd10, 5'd31, 39,   32'd100,        0, 0};
      tbl[5] = '{"div_lat40", 0, 1, 32'd1000,       32'd10, 5'd2,  40,   32'd0,          1, 1};
      tbl[6] = '{"mul_lat0",  1, 0, 32'hFFFFFFFF,   32'd2,  5'd5,  0,    32'hFFFFFFFE,   0, 0};
      tbl[7] = '{"div_neg",   0, 1, 32'hFFFFFFEC,   32'd4,  5'd6,  7,    32'hFFFFFFFB,   0, 0};

      rst = 1'b1;
      drive_op(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      chk("rst stall",    bus.stall, 0);
      chk("rst wb_valid", bus.wb_valid, 0);
      chk("rst pulses",   {bus.md_ctrl_MULT, bus.md_ctrl_DIV}, 0);
      chk("rst opA",      bus.md_operandA, 0);
      chk("rst opB",      bus.md_operandB, 0);
      chk("rst wb_bus",   {bus.wb_result, bus.wb_dest, bus.wb_exception, bus.wb_timeout}, 0);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) run_op(tbl[i]);

      run_illegal("neither_sel");

      // Back-to-back: op2 waits on the bus while op1 runs and is taken in op1's DONE.
      md_lat = 2;
      @(posedge clk); #1;
      drive_op(1, 0, 1, 32'd9, 32'd3, 5'd7);
      @(posedge clk); #1;
      drive_op(1, 1, 0, 32'hFFFFFFFE, 32'd3, 5'd9);
      mul_cyc = -1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (bus.md_ctrl_MULT) mul_cyc = c;
         if (bus.wb_valid) begin
            wb_cyc.push_back(c);
            wb_res.push_back(bus.wb_result);
            wb_dst.push_back(bus.wb_dest);
            if (c == 5) chk("b2b stall_in_done", bus.stall, 1);
         end
         if (c == 6) begin @(posedge clk); #1 drive_op(0, 0, 0, 0, 0, 0); end
      end
      chk("b2b wb_count", wb_cyc.size(), 2);
      if (wb_cyc.size() == 2) begin
         chk("b2b op1_cyc", wb_cyc[0], 5);
         chk("b2b op1_res", wb_res[0], 32'd3);
         chk("b2b op1_dst", wb_dst[0], 5'd7);
         chk("b2b op2_cyc", wb_cyc[1], 10);
         chk("b2b op2_res", wb_res[1], 32'hFFFFFFFA);
         chk("b2b op2_dst", wb_dst[1], 5'd9);
      end
      chk("b2b mul_pulse_cyc", mul_cyc, 6);

      // Reset on WAIT cycle 5, then the late ready must be ignored.
      md_lat = 20;
      @(posedge clk); #1;
      drive_op(1, 1, 0, 32'd5, 32'd5, 5'd3);
      @(posedge clk); #1;
      drive_op(0, 0, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst stall",  bus.stall, 0);
      chk("midrst pulses", {bus.md_ctrl_MULT, bus.md_ctrl_DIV, bus.wb_valid}, 0);
      chk("midrst opnds",  {bus.md_operandA, bus.md_operandB}, 0);
      chk("midrst wb_bus", {bus.wb_result, bus.wb_dest, bus.wb_exception, bus.wb_timeout}, 0);
      @(posedge clk); #1 rst = 1'b0;
      bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (bus.wb_valid || bus.md_ctrl_MULT || bus.md_ctrl_DIV || bus.stall) bad++;
      end
      chk("midrst late_ready_ignored", bad, 0);

      rv = '{"post_rst", 1, 0, 32'd11, 32'd12, 5'd8, 4, 32'd132, 0, 0};
      run_op(rv);

      for (int i = 0; i < 12; i++) begin
         int kind;
         kind   = $urandom_range(0, 3);
         rv.nm  = $sformatf("rnd%0d", i);
         rv.d   = (kind != 0);
         rv.m   = (kind != 1);
         rv.a   = $urandom;
         rv.b   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
         rv.dst = 5'($urandom);
         rv.lat = $urandom_range(0, 45);
         if (kind == 3) begin
            run_illegal(rv.nm);
         end else begin
            r     = md_calc(rv.d, rv.a, rv.b);
            rv.er = (rv.lat >= TO) ? 32'd0 : r[31:0];
            rv.ee = (rv.lat >= TO) ? 1'b1 : r[32];
            rv.et = (rv.lat >= TO);
            run_op(rv);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/multdiv_issue_ctrl.md
MULTDIV_ISSUE_CTRL -- requirements
Module: multdiv_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 40: maximum number of WAIT cycles allowed before the operation is abandoned.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge clock shared with the multdiv unit.
REQ-004 reset  input  1  asynchronous, active-high clear.
REQ-005 op_valid  input  1  decode stage presents a multiply or divide instruction.
REQ-006 is_mult, is_div  input  1 each  operation select.
REQ-007 op_A, op_B  input  32 each  source operands.
REQ-008 op_dest  input  5  destination register.
REQ-009 md_operandA, md_operandB  output  32 each  operands driven to the multdiv unit.
REQ-010 md_ctrl_MULT, md_ctrl_DIV  output  1 each  single-cycle start pulses.
REQ-011 md_result  input  32; md_exception  input  1; md_resultRDY  input  1  multdiv unit returns.
REQ-012 stall  output  1  freezes upstream pipeline stages.
REQ-013 wb_valid  output  1; wb_result  output  32; wb_dest  output  5; wb_exception  output  1; wb_timeout  output  1  writeback port.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT, DONE.
REQ-015 IDLE or DONE with op_valid and (is_mult or is_div): on that edge, latch op_A, op_B, op_dest and op type, then go to START.
REQ-016 When is_mult and is_div are both high, the block SHALL issue DIV.
REQ-017 When op_valid is high but neither select is high, the block SHALL ignore the op and stay in or return to IDLE.
REQ-018 START SHALL assert exactly one of md_ctrl_MULT / md_ctrl_DIV for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-019 md_operandA/B SHALL equal the latched operands from START through DONE and SHALL be stable for the whole operation.
REQ-020 md_resultRDY SHALL be ignored in START, because it may still show the previous operation's ready.
REQ-021 WAIT with md_resultRDY=1: capture md_result and md_exception, then go to DONE.
REQ-022 WAIT without md_resultRDY: increment the counter; when the counter equals TIMEOUT-1, go to DONE with result 0, exception 1 and timeout 1.
REQ-023 DONE SHALL hold wb_valid=1 for exactly one cycle with the captured wb_result, wb_dest, wb_exception and wb_timeout, then go to IDLE unless a new op is accepted (REQ-015).
REQ-024 stall SHALL be combinational: high when (IDLE or DONE) and a legal op_valid is present, and in START and WAIT; low otherwise.
REQ-025 Latency from op acceptance to wb_valid SHALL be 3 + N cycles, where N is the number of WAIT cycles before md_resultRDY.
REQ-026 The wait counter SHALL be ceil(log2(TIMEOUT))+1 bits wide and SHALL saturate, never wrap.
REQ-027 wb_* outputs SHALL be 0 whenever wb_valid=0.

Reset
REQ-028 Reset SHALL force IDLE and clear all latched registers and the counter to 0.
REQ-029 Reset SHALL drive every output to 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation with no wb_valid and no further ctrl pulse, and any late md_resultRDY SHALL be ignored.
REQ-031 The first op accepted after reset deasserts SHALL behave per REQ-015.

Structure
REQ-032 The state encodings (2-bit) and the default TIMEOUT constant SHALL live in the shared multdiv package/header.
REQ-033 The wait counter SHALL be one sub-module, md_wait_counter (clear, enable, saturate, terminal-count flag), built on the codebase's dffe_ref flops.
REQ-034 The block SHALL instantiate no arithmetic; it connects to the existing multdiv unit only through its ports.

Verification (bench uses a behavioural multdiv model with programmable latency)
REQ-035 MULT 6 x 7, latency 17 -> one md_ctrl_MULT pulse the cycle after acceptance; wb_valid with wb_result=42, wb_exception=0; stall high for 20 cycles.
REQ-036 DIV 100 / 0 -> md_ctrl_DIV pulse; model returns exception -> wb_exception=1, wb_timeout=0, wb_dest equals the latched value.
REQ-037 Model never raises ready, TIMEOUT=40 -> DONE after 40 WAIT cycles with wb_result=0, wb_exception=1, wb_timeout=1.
REQ-038 Reset pulsed on WAIT cycle 5 -> all outputs 0 next cycle; a later md_resultRDY produces no wb_valid.
REQ-039 Back-to-back DIV 9/3 then MULT -2 x 3 with op_valid held through DONE -> wb results 3 then 0xFFFFFFFA, no idle gap, ready from op1 ignored during op2 START.
REQ-040 is_mult=is_div=1 -> only md_ctrl_DIV pulses; op_valid with neither select high -> stall stays 0 and no pulse occurs.
